// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit: radix-2 shift-add multiply and restoring divide, 32 cycles each.
// Divider datapath is built only when MULDIV_DIV_EN is defined; otherwise DIVU/REMU retire 0 after one cycle.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_address,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] result,
    output logic [4:0]  result_rd_address,
    output logic        result_valid
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    state_t      state;
    logic [5:0]  count;
    logic [1:0]  op_q;
    logic [4:0]  rd_q;

    // Multiplier: acc starts as {0, multiplier}; each step adds the multiplicand
    // into the upper half when the current LSB is set, then shifts right.
    logic [31:0] mcand;
    logic [63:0] acc;
    logic [32:0] mul_sum;
    logic [63:0] acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mcand : 32'd0)};
        acc_next = {mul_sum, acc[31:1]};
    end

`ifdef MULDIV_DIV_EN
    // Restoring divider: the dividend shifts out of quo MSB-first into the
    // partial remainder; quotient bits shift into quo from the bottom.
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    always_comb begin
        shifted  = {rem, quo[31]};
        fits     = (shifted >= {1'b0, divisor});
        diff     = shifted[31:0] - divisor;
        rem_next = fits ? diff : shifted[31:0];
        quo_next = {quo[30:0], fits};
    end
`endif

    logic        fast_path;
    logic [31:0] fast_result;
    logic [31:0] run_result;

    always_comb begin
`ifdef MULDIV_DIV_EN
        fast_path   = op[1] && (rs2_data == 32'd0);
        fast_result = op[0] ? rs1_data : '1;
`else
        fast_path   = op[1];
        fast_result = '0;
`endif
        case (op_q)
            OP_MUL:   run_result = acc_next[31:0];
            OP_MULHU: run_result = acc_next[63:32];
`ifdef MULDIV_DIV_EN
            OP_DIVU:  run_result = quo_next;
            OP_REMU:  run_result = rem_next;
`else
            OP_DIVU:  run_result = '0;
            OP_REMU:  run_result = '0;
`endif
            default:  run_result = '0;
        endcase
    end

    // stall must respond in the issue cycle, so it is combinational on start.
    always_comb begin
        stall = reset_n && (((state == IDLE) && start && !flush) || (state == RUN));
        busy  = reset_n && (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            count             <= '0;
            op_q              <= '0;
            rd_q              <= '0;
            mcand             <= '0;
            acc               <= '0;
`ifdef MULDIV_DIV_EN
            divisor           <= '0;
            quo               <= '0;
            rem               <= '0;
`endif
            result            <= '0;
            result_rd_address <= '0;
            result_valid      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (fast_path) begin
                                state             <= DONE;
                                result            <= fast_result;
                                result_rd_address <= rd_address;
                                result_valid      <= 1'b1;
                            end else begin
                                state   <= RUN;
                                count   <= '0;
                                op_q    <= op;
                                rd_q    <= rd_address;
                                mcand   <= rs2_data;
                                acc     <= {32'd0, rs1_data};
`ifdef MULDIV_DIV_EN
                                divisor <= rs2_data;
                                quo     <= rs1_data;
                                rem     <= '0;
`endif
                            end
                        end
                    end
                    RUN: begin
                        acc   <= acc_next;
`ifdef MULDIV_DIV_EN
                        quo   <= quo_next;
                        rem   <= rem_next;
`endif
                        count <= count + 6'd1;
                        if (count == 6'd31) begin
                            state             <= DONE;
                            result            <= run_result;
                            result_rd_address <= rd_q;
                            result_valid      <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, flush/reset/back-to-back
// sequences and random operations against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_address;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic [4:0]  result_rd_address;
    logic        result_valid;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_result;
    logic [4:0]  last_rd;

    ex_muldiv_unit dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .op                (op),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .rd_address        (rd_address),
        .flush             (flush),
        .stall             (stall),
        .busy              (busy),
        .result            (result),
        .result_rd_address (result_rd_address),
        .result_valid      (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the architectural definition of each op.
    function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            2'b00: return p[31:0];
            2'b01: return p[63:32];
`ifdef MULDIV_DIV_EN
            2'b10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    function automatic int model_latency(input logic [1:0] o, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        return (o[1] && b == 0) ? 1 : 33;
`else
        if (b == 32'h1234_5678) return 33;
        return o[1] ? 1 : 33;
`endif
    endfunction

    // Issues one op in cycle 0 and checks stall/busy/result_valid every cycle up to retirement.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat,
                          input bit keep_start, input bit no_wait, input string name);
        if (!no_wait) @(negedge clk);
        start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_address = rd;
        #1;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) @(negedge clk);
            check({name, " stall"}, 64'(stall), 64'(k < lat));
            check({name, " busy"}, 64'(busy), 64'(k > 0));
            check({name, " result_valid"}, 64'(result_valid), 64'(k == lat));
            if (k == lat) begin
                check({name, " result"}, 64'(result), 64'(exp));
                check({name, " result_rd_address"}, 64'(result_rd_address), 64'(rd));
            end
        end
        if (!keep_start) start = 1'b0;
        last_result = exp;
        last_rd     = rd;
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'b00, 32'd7,          32'd6,          5'd5,  32'd42,          33};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE,   33};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001,   33};
`ifdef MULDIV_DIV_EN
        vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd3,  32'd14,          33};
        vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd4,  32'd2,           33};
        vecs[5] = '{2'b10, 32'd100,        32'd0,          5'd6,  32'hFFFF_FFFF,   1};
        vecs[6] = '{2'b11, 32'd100,        32'd0,          5'd31, 32'd100,         1};
`else
        vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd3,  32'd0,           1};
        vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd4,  32'd0,           1};
        vecs[5] = '{2'b10, 32'd100,        32'd0,          5'd6,  32'd0,           1};
        vecs[6] = '{2'b11, 32'd100,        32'd0,          5'd31, 32'd0,           1};
`endif

        // Reset state, with start high to confirm stall/busy are forced low.
        reset_n = 1'b0; start = 1'b1; op = 2'b00; rs1_data = 32'd1; rs2_data = 32'd1;
        rd_address = 5'd1; flush = 1'b0;
        #12;
        check("reset stall", 64'(stall), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset result_rd_address", 64'(result_rd_address), 64'd0);
        check("reset result_valid", 64'(result_valid), 64'd0);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        last_result = '0;
        last_rd = '0;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat, 1'b0, 1'b0,
                   $sformatf("vec%0d", i));

        // Flush during RUN cycle 10, then a fresh MUL in the very next cycle.
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1_data = 32'd1000; rs2_data = 32'd77; rd_address = 5'd9;
        #1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("flush pre stall", 64'(stall), 64'd1);
        end
        start = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush result_valid", 64'(result_valid), 64'd0);
        check("flush result kept", 64'(result), 64'(last_result));
        check("flush rd kept", 64'(result_rd_address), 64'(last_rd));
        run_op(2'b00, 32'd3, 32'd3, 5'd12, 32'd9, 33, 1'b0, 1'b1, "post-flush mul");

        // Reset during RUN cycle 20, start still asserted.
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1_data = 32'd123; rs2_data = 32'd456; rd_address = 5'd7;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrun reset stall", 64'(stall), 64'd0);
        check("midrun reset busy", 64'(busy), 64'd0);
        check("midrun reset result_valid", 64'(result_valid), 64'd0);
        check("midrun reset result", 64'(result), 64'd0);
        check("midrun reset rd", 64'(result_rd_address), 64'd0);
        @(negedge clk);
        check("held reset stall", 64'(stall), 64'd0);
        reset_n = 1'b1; start = 1'b0;
        run_op(2'b10, 32'd9, 32'd2, 5'd3, model_result(2'b10, 32'd9, 32'd2),
               model_latency(2'b10, 32'd2), 1'b0, 1'b0, "post-reset divu");

        // Back-to-back with start held through DONE: exactly two pulses.
        run_op(2'b00, 32'd2, 32'd2, 5'd10, 32'd4, 33, 1'b1, 1'b0, "b2b first");
        run_op(2'b00, 32'd3, 32'd3, 5'd11, 32'd9, 33, 1'b0, 1'b0, "b2b second");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("b2b no extra pulse", 64'(result_valid), 64'd0);
        end

        // Random operations, with an occasional zero divisor.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            logic [4:0]  rd;
            o  = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (b == 32'h1234_5678) b = 32'd5;
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            run_op(o, a, b, rd, model_result(o, a, b), model_latency(o, b), 1'b0, 1'b0,
                   $sformatf("rand%0d op%0d", i, o));
        end

        @(negedge clk);
        check("final idle busy", 64'(busy), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
